// File: rtl/apuf_eval_ctrl.sv
// Arbiter PUF challenge/response sequencer: settle, trigger, synchronised sample.
// Define MAJORITY_VOTE_EN to evaluate NREP times per challenge and majority-vote.
module apuf_eval_ctrl #(
    parameter int nStage  = 64,
    parameter int SETTLE  = 4,
    parameter int TIMEOUT = 255,
    parameter int NREP    = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ch_valid,
    output logic              ch_ready,
    input  logic [nStage-1:0] ch_data,
    output logic [nStage-1:0] c,
    output logic              tigSignal,
    input  logic              respReady,
    input  logic              respBit,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_bit,
    output logic              resp_err
);

    localparam int CW = $clog2(NREP + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_FIRE,
        S_WAIT_HI,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic [nStage-1:0] c_q, c_d;
    logic              tig_q, tig_d;
    logic              err_q, err_d;
    logic [7:0]        stl_q, stl_d;
    logic [15:0]       tmo_q, tmo_d;
    logic [CW-1:0]     ones_q, ones_d;
    logic              rr_m_q, rr_s;
    logic              rb_m_q, rb_s;
    logic              vote;
`ifdef MAJORITY_VOTE_EN
    logic [CW-1:0]     rep_q, rep_d;
`endif

    // Two-flop synchronisers for the PUF's asynchronous outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_m_q <= 1'b0;
            rr_s   <= 1'b0;
            rb_m_q <= 1'b0;
            rb_s   <= 1'b0;
        end else begin
            rr_m_q <= respReady;
            rr_s   <= rr_m_q;
            rb_m_q <= respBit;
            rb_s   <= rb_m_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            tig_q   <= 1'b0;
            err_q   <= 1'b0;
            stl_q   <= '0;
            tmo_q   <= '0;
            ones_q  <= '0;
`ifdef MAJORITY_VOTE_EN
            rep_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            tig_q   <= tig_d;
            err_q   <= err_d;
            stl_q   <= stl_d;
            tmo_q   <= tmo_d;
            ones_q  <= ones_d;
`ifdef MAJORITY_VOTE_EN
            rep_q   <= rep_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        tig_d   = tig_q;
        err_d   = err_q;
        stl_d   = stl_q;
        tmo_d   = tmo_q;
        ones_d  = ones_q;
`ifdef MAJORITY_VOTE_EN
        rep_d   = rep_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (ch_valid) begin
                    c_d     = ch_data;
                    ones_d  = '0;
`ifdef MAJORITY_VOTE_EN
                    rep_d   = '0;
`endif
                    err_d   = 1'b0;
                    stl_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (stl_q == 8'(SETTLE - 1)) begin
                    stl_d   = '0;
                    state_d = S_FIRE;
                end else begin
                    stl_d = stl_q + 8'd1;
                end
            end
            S_FIRE: begin
                tig_d   = 1'b1;
                tmo_d   = '0;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (rr_s) begin
                    ones_d  = ones_q + CW'(rb_s);
                    tig_d   = 1'b0;
                    tmo_d   = '0;
                    state_d = S_DRAIN;
                end else if (tmo_q == 16'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    tig_d   = 1'b0;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_DRAIN: begin
                if (!rr_s) begin
                    state_d = S_DONE;
`ifdef MAJORITY_VOTE_EN
                    if (rep_q != CW'(NREP - 1)) begin
                        rep_d   = rep_q + CW'(1);
                        stl_d   = '0;
                        state_d = S_SETTLE;
                    end
`endif
                end else if (tmo_q == 16'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            S_DONE: begin
                if (resp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef MAJORITY_VOTE_EN
    assign vote = ones_q > CW'(NREP / 2);
`else
    // Only one sample is ever added, so any set bit is that sample
    assign vote = |ones_q;
`endif

    always_comb begin
        ch_ready   = (state_q == S_IDLE);
        resp_valid = (state_q == S_DONE);
        resp_err   = resp_valid & err_q;
        resp_bit   = resp_valid & ~err_q & vote;
    end

    assign c         = c_q;
    assign tigSignal = tig_q;

endmodule

// File: tb/tb_apuf_eval_ctrl.sv
// Directed, table-driven bench for apuf_eval_ctrl with a cycle-level PUF model.
// Works for both the single-evaluation and MAJORITY_VOTE_EN builds.
module tb_apuf_eval_ctrl;

    localparam int NS = 64;
`ifdef MAJORITY_VOTE_EN
    localparam int P = 5;
`else
    localparam int P = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ch_valid;
    logic          ch_ready;
    logic [NS-1:0] ch_data;
    logic [NS-1:0] c;
    logic          tigSignal;
    logic          respReady;
    logic          respBit;
    logic          resp_valid;
    logic          resp_ready;
    logic          resp_bit;
    logic          resp_err;

    apuf_eval_ctrl #(
        .nStage (NS),
        .SETTLE (4),
        .TIMEOUT(20),
        .NREP   (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_valid  (ch_valid),
        .ch_ready  (ch_ready),
        .ch_data   (ch_data),
        .c         (c),
        .tigSignal (tigSignal),
        .respReady (respReady),
        .respBit   (respBit),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_bit  (resp_bit),
        .resp_err  (resp_err)
    );

    always #5 clk = ~clk;

    // mode 0: respond after dly, 1: never respond, 2: respReady sticks high
    int       mode = 0;
    int       dly = 10;
    logic [4:0] bits = '0;
    int       base = 0;
    int       ev_cnt;
    int       k;

    initial begin
        k = 0;
        ev_cnt = 0;
        respReady = 1'b0;
        respBit = 1'b0;
        forever begin
            @(negedge clk);
            if (tigSignal) begin
                k++;
                if (k == dly && mode != 1) begin
                    respBit = bits[(ev_cnt - base) % 5];
                    respReady = 1'b1;
                    ev_cnt++;
                end
            end else begin
                k = 0;
                if (mode != 2) respReady = 1'b0;
            end
        end
    end

    typedef struct {
        logic [63:0] data;
        int          dly;
        int          mode;
        logic [4:0]  bits;
        logic        xbit;
        logic        xerr;
        int          xpulses;
        int          xtw;
        int          xfd;
        bit          pre_rdy;
    } rec_t;

    rec_t tbl[6];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [63:0] d);
        int n;
        ch_data = d;
        ch_valid = 1'b1;
        n = 0;
        while (!ch_ready && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) chk("accept_wait", 64'(ch_ready), 64'd1);
        step();
        ch_valid = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!resp_valid && n < 2000) begin
            step();
            n++;
        end
        if (n >= 2000) chk("resp_valid_wait", 64'(resp_valid), 64'd1);
    endtask

    task automatic run(input rec_t r);
        int   st, n, nf, pulses, tw;
        logic prev, fell, cok;
        mode = r.mode;
        dly = r.dly;
        bits = r.bits;
        base = ev_cnt;
        if (r.pre_rdy) resp_ready = 1'b1;
        accept(r.data);
        chk("c_load", c, r.data);
        st = 1;
        while (!tigSignal && st < 40) begin
            step();
            st++;
        end
        chk("tig_rise_cycle", 64'(st), 64'd6);
        pulses = 1;
        prev = 1'b1;
        fell = 1'b0;
        cok = 1'b1;
        tw = 0;
        nf = 0;
        n = 0;
        while (!resp_valid && n < 2000) begin
            step();
            n++;
            if (c !== r.data) cok = 1'b0;
            if (tigSignal && !prev) pulses++;
            if (!fell && !tigSignal) begin
                fell = 1'b1;
                tw = n;
                nf = n;
            end
            prev = tigSignal;
        end
        if (n >= 2000) chk("resp_valid_wait", 64'(resp_valid), 64'd1);
        chk("tig_pulses", 64'(pulses), 64'(r.xpulses));
        chk("c_stable", 64'(cok), 64'd1);
        if (r.xtw != 0) chk("tig_width", 64'(tw), 64'(r.xtw));
        if (r.xfd != 0) chk("drain_len", 64'(n - nf), 64'(r.xfd));
        chk("resp_bit", 64'(resp_bit), 64'(r.xbit));
        chk("resp_err", 64'(resp_err), 64'(r.xerr));
        chk("ch_ready_in_done", 64'(ch_ready), 64'd0);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("resp_consumed", 64'(resp_valid), 64'd0);
        chk("back_to_idle", 64'(ch_ready), 64'd1);
        mode = 0;
        repeat (3) step();
    endtask

    initial begin
        logic       sb, se, ok;
        logic [63:0] wa, wb;
        int         n;
        tbl[0] = '{64'hA5A5_0000_FFFF_1234, 10, 0, 5'b01101, 1'b1, 1'b0, P, 0, 0, 1'b0};
        tbl[1] = '{64'h0123_4567_89AB_CDEF, 3, 0, 5'b10100, 1'b0, 1'b0, P, 0, 0, 1'b0};
        tbl[2] = '{64'hFFFF_FFFF_FFFF_FFFF, 15, 1, 5'b11111, 1'b0, 1'b1, 1, 21, 0, 1'b0};
        tbl[3] = '{64'h0000_0000_0000_0001, 4, 2, 5'b11111, 1'b0, 1'b1, 1, 0, 21, 1'b0};
        tbl[4] = '{64'h8000_0000_0000_0000, 6, 0, 5'b11111, 1'b1, 1'b0, P, 0, 0, 1'b1};
        tbl[5] = '{64'h1357_9BDF_0246_8ACE, 12, 0, 5'b11000, 1'b0, 1'b0, P, 0, 0, 1'b0};

        rst_n = 1'b0;
        ch_valid = 1'b0;
        ch_data = '0;
        resp_ready = 1'b0;
        repeat (3) step();
        chk("rst_c", c, 64'd0);
        chk("rst_tig", 64'(tigSignal), 64'd0);
        chk("rst_ch_ready", 64'(ch_ready), 64'd1);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_bit", 64'(resp_bit), 64'd0);
        chk("rst_resp_err", 64'(resp_err), 64'd0);
        rst_n = 1'b1;
        repeat (2) step();

        for (int i = 0; i < 6; i++) run(tbl[i]);

        // Backpressure: result held 50 cycles while a second challenge waits
        wa = 64'hCAFE_F00D_0000_0042;
        wb = 64'h0BAD_BEEF_1111_2222;
        mode = 0;
        dly = 5;
        bits = 5'b11111;
        base = ev_cnt;
        accept(wa);
        wait_valid(n);
        sb = resp_bit;
        se = resp_err;
        chk("bp_bit", 64'(sb), 64'd1);
        ch_data = wb;
        ch_valid = 1'b1;
        ok = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step();
            if (!resp_valid || resp_bit !== sb || resp_err !== se ||
                ch_ready || c !== wa) ok = 1'b0;
        end
        chk("bp_hold", 64'(ok), 64'd1);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        chk("bp_release_ready", 64'(ch_ready), 64'd1);
        chk("bp_c_still_a", c, wa);
        step();
        ch_valid = 1'b0;
        chk("bp_second_accepted", c, wb);
        wait_valid(n);
        chk("bp_second_bit", 64'(resp_bit), 64'd1);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        repeat (3) step();

        // Reset while the trigger is high
        mode = 1;
        accept(64'hDEAD_0000_BEEF_0000);
        n = 0;
        while (!tigSignal && n < 40) begin
            step();
            n++;
        end
        chk("mid_tig_high", 64'(tigSignal), 64'd1);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_tig", 64'(tigSignal), 64'd0);
        chk("mid_rst_ch_ready", 64'(ch_ready), 64'd1);
        chk("mid_rst_valid", 64'(resp_valid), 64'd0);
        chk("mid_rst_c", c, 64'd0);
        step();
        rst_n = 1'b1;
        mode = 0;
        repeat (3) step();
        run(tbl[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
